// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - shared RV32M multiplier types and constants
package rv32m_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } mul_state_t;

  localparam int MUL_ITER = 32;

endpackage

// File: rtl/adder_b.sv
// rtl/adder_b.sv - generate/propagate carry adder, (n_bit+1) bits wide
module adder_b #(
  parameter int n_bit = 31
) (
  input  logic [n_bit:0] i_a,
  input  logic [n_bit:0] i_b,
  input  logic           i_cin,
  output logic [n_bit:0] o_sum,
  output logic           o_cout
);

  logic [n_bit:0]   w_g;
  logic [n_bit:0]   w_p;
  logic [n_bit+1:0] w_c;

  always_comb begin
    w_g    = i_a & i_b;
    w_p    = i_a ^ i_b;
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i <= n_bit; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
    o_sum  = w_p ^ w_c[n_bit:0];
    o_cout = w_c[n_bit+1];
  end

endmodule

// File: rtl/mul32_seq.sv
// rtl/mul32_seq.sv - iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU
module mul32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  import rv32m_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);

  mul_state_t       r_state;
  mul_op_t          r_op;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mlo;
  logic [WIDTH-1:0] r_acc_hi;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;

  mul_op_t            w_op;
  logic               w_rs1_neg;
  logic               w_rs2_neg;
  logic [WIDTH-1:0]   w_rs1_mag;
  logic [WIDTH-1:0]   w_rs2_mag;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;

  // MUL keeps both flags clear: the low half is identical for signed and unsigned.
  always_comb begin
    w_op       = mul_op_t'(op);
    w_rs1_neg  = ((w_op == OP_MULH) || (w_op == OP_MULHSU)) && rs1[WIDTH-1];
    w_rs2_neg  = (w_op == OP_MULH) && rs2[WIDTH-1];
    w_rs1_mag  = w_rs1_neg ? (~rs1 + WIDTH'(1)) : rs1;
    w_rs2_mag  = w_rs2_neg ? (~rs2 + WIDTH'(1)) : rs2;
    w_addend   = r_mlo[0] ? r_mcand : '0;
    w_prod     = {r_acc_hi, r_mlo};
    w_prod_fix = r_neg ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
  end

  adder_b #(
    .n_bit (WIDTH-1)
  ) u_adder (
    .i_a    (r_acc_hi),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_MUL;
      r_mcand     <= '0;
      r_mlo       <= '0;
      r_acc_hi    <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op     <= w_op;
            r_mcand  <= w_rs1_mag;
            r_mlo    <= w_rs2_mag;
            r_neg    <= w_rs1_neg ^ w_rs2_neg;
            r_acc_hi <= '0;
            r_cnt    <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          // {carry, sum, mlo} >> 1: the retired multiplier bit falls off the bottom.
          r_acc_hi <= {w_cout, w_sum[WIDTH-1:1]};
          r_mlo    <= {w_sum[0], r_mlo[WIDTH-1:1]};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(MUL_ITER - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_result    <= (r_op == OP_MUL) ? w_prod_fix[WIDTH-1:0] : w_prod_fix[2*WIDTH-1:WIDTH];
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule

// File: tb/tb_mul32_seq.sv
// tb/tb_mul32_seq.sv - self-checking bench for mul32_seq against an arithmetic reference
module tb_mul32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  mul32_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub_s;
    logic [63:0] ua, ub, p;
    sa   = $signed({{32{a[31]}}, a});
    sb   = $signed({{32{b[31]}}, b});
    ua   = {32'h0, a};
    ub   = {32'h0, b};
    ub_s = $signed(ub);
    case (o)
      2'b00:   p = ua * ub;
      2'b01:   p = sa * sb;
      2'b10:   p = sa * ub_s;
      default: p = ua * ub;
    endcase
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int bp, input bit intrude, input string tag);
    logic [31:0] exp;
    logic [31:0] held;
    int lat;
    exp = ref_mul(o, a, b);
    check({tag, "/in_ready_idle"}, 64'(in_ready), 64'd1);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
    check({tag, "/busy_after_accept"}, {62'd0, busy, in_ready}, 64'd2);
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid = intrude && (lat == 10);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "/latency"}, 64'(lat), 64'd33);
    check({tag, "/result"}, 64'(result), 64'(exp));
    held = result;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check({tag, "/bp_hold"}, {31'd0, out_valid, result}, {31'd0, 1'b1, held});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/post_handshake"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_state", {29'd0, in_ready, out_valid, busy, result}, {29'd0, 3'b100, 32'h0});

    run_op(2'b00, 32'd7, 32'd6, 0, 1'b0, "mul_7x6");
    check("mul_7x6_const", 64'(ref_mul(2'b00, 32'd7, 32'd6)), 64'h2A);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, "mulh_min_min");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, "mul_min_min");
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "mulhsu_m1");
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "mulhu_max");
    run_op(2'b01, 32'hFFFF_FFFE, 32'd3, 0, 1'b0, "mulh_m2x3");
    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 0, 1'b0, "mul_m2x3");
    run_op(2'b01, 32'h1234_5678, 32'h8765_4321, 10, 1'b1, "mulh_bp_intrude");

    // Abort mid-calculation with a one-cycle reset pulse.
    op = 2'b11; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1357_9BDF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_abort_state", {61'd0, in_ready, out_valid, busy}, 64'b100);
    repeat (40) begin
      @(posedge clk); #1;
      check("rst_abort_no_output", 64'(out_valid), 64'd0);
    end
    run_op(2'b11, 32'h0001_0000, 32'h0001_0000, 0, 1'b0, "mulhu_after_rst");

    for (int n = 0; n < 30; n++) begin
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
